// File: rtl/seq_encoder_if.sv
// Request/code bundle between the encoder and its producer/consumer.
// Master drives start/D/RDY; slave (the encoder) drives the code side.
interface seq_encoder_if #(
  parameter int W  = 8,
  parameter int YW = 3
);
  logic          start;
  logic [W-1:0]  D;
  logic          RDY;
  logic [YW-1:0] Y;
  logic          V;
  logic          busy;
  logic          done;
  logic [YW:0]   Cnt;

  modport master (
    output start, D, RDY,
    input  Y, V, busy, done, Cnt
  );

  modport slave (
    input  start, D, RDY,
    output Y, V, busy, done, Cnt
  );
endinterface

// File: rtl/seq_encoder.sv
// Sequential priority encoder: emits the index of every set bit of a
// captured mask, highest first, one code per accepted handshake.
module seq_encoder #(
  parameter int W  = 8,
  parameter int YW = 3
) (
  input  logic clk,
  input  logic rst_n,
  seq_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_m;
  logic [YW-1:0] r_y;
  logic          r_v;
  logic          r_busy;
  logic          r_done;
  logic [YW:0]   r_cnt;

  logic [W-1:0]  w_bit;
  logic [W-1:0]  w_m_clr;

  function automatic logic [YW-1:0] msb_idx(
    input logic [W-1:0] m
  );
    logic [YW-1:0] idx;
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (m[i]) idx = YW'(i);
    end
    return idx;
  endfunction

  // Mask with the currently presented code removed.
  assign w_bit   = W'(1) << r_y;
  assign w_m_clr = r_m & ~w_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_y     <= '0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_m    <= bus.D;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (|bus.D) begin
              r_state <= SCAN;
              r_v     <= 1'b1;
              r_y     <= msb_idx(bus.D);
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (bus.RDY) begin
            r_m   <= w_m_clr;
            r_cnt <= r_cnt + 1'b1;
            if (|w_m_clr) begin
              r_y <= msb_idx(w_m_clr);
            end else begin
              r_v     <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Y    = r_y;
  assign bus.V    = r_v;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.Cnt  = r_cnt;

endmodule

// File: doc/seq_encoder.md
SEQ_ENCODER -- requirements
Module: seq_encoder

Interface
REQ-001 SHALL have parameter W, default 8, meaning the request vector width, legal values 2..16.
REQ-002 SHALL have parameter YW, default 3, meaning the code width, which SHALL equal ceil(log2(W)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to capture D and begin encoding.
REQ-006 SHALL have port D, input, W bits: request vector, sampled only when a start is accepted.
REQ-007 SHALL have port RDY, input, 1 bit: consumer ready for the current code.
REQ-008 SHALL have port Y, output, YW bits: binary index of the current highest-priority set bit.
REQ-009 SHALL have port V, output, 1 bit: Y is valid.
REQ-010 SHALL have port busy, output, 1 bit: high in SCAN and DONE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle end-of-job pulse.
REQ-012 SHALL have port Cnt, output, YW+1 bits: number of codes accepted in the current or last job.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, SCAN and DONE; all outputs SHALL be registered.
REQ-014 IDLE: start=1 at a rising edge SHALL capture D into internal mask M, clear Cnt to 0, and move to SCAN if D!=0, else to DONE.
REQ-015 SCAN: V SHALL be 1 and Y SHALL be the index of the most significant set bit of M (bit W-1 is the highest priority).
REQ-016 First valid code SHALL appear in the cycle after start is accepted (latency 1).
REQ-017 Handshake: a code SHALL be accepted only on an edge with V=1 and RDY=1; the accepted bit SHALL be cleared from M and Cnt SHALL increment by 1.
REQ-018 With V=1 and RDY=0, Y, V and M SHALL hold unchanged for any number of cycles.
REQ-019 If M becomes zero after an acceptance, the next state SHALL be DONE with V=0; otherwise the state SHALL stay SCAN, with Y updating to the next set bit in the following cycle.
REQ-020 With RDY held high, a job with k set bits SHALL produce k codes on k consecutive cycles, with no bubbles.
REQ-021 DONE: done SHALL be 1 and V SHALL be 0 for exactly one cycle, then the state SHALL return to IDLE.
REQ-022 busy SHALL be 1 exactly when the state is SCAN or DONE.
REQ-023 start asserted in SCAN or DONE SHALL be ignored and SHALL NOT affect M, Cnt or the state.
REQ-024 start asserted in the IDLE cycle directly after DONE SHALL be accepted normally (back-to-back jobs).
REQ-025 Changes on D outside an accepted start SHALL have no effect.
REQ-026 Cnt SHALL hold its final value in IDLE until the next accepted start; it SHALL NOT wrap, since its maximum is W.
REQ-027 Y SHALL hold its last value when V=0; consumers SHALL NOT interpret Y when V=0.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, M=0, Y=0, V=0, busy=0, done=0 and Cnt=0.
REQ-029 Reset asserted mid-job SHALL abort the job with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-030 The first start SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-031 Full run: D=8'b1010_0110, start for 1 cycle, RDY=1 -> Y=7,5,2,1 on 4 consecutive cycles with V=1, then done=1 for 1 cycle, Cnt=4.
REQ-032 Empty job: D=8'h00, start -> V never 1, done=1 in the cycle after start, Cnt=0, busy=1 for 1 cycle.
REQ-033 Backpressure: D=8'h81, RDY=0 for 3 cycles then 1 -> Y=7 with V=1 held 4 cycles, then Y=0, then done; Cnt=2.
REQ-034 Start during SCAN: D=8'hF0, re-pulse start with D=8'h0F mid-job -> codes 7,6,5,4 only; Cnt=4.
REQ-035 Reset mid-job: D=8'hFF, drop rst_n after 3 codes -> all outputs 0 asynchronously, no done pulse; a following start with D=8'h01 -> Y=0, Cnt=1.
REQ-036 Back-to-back jobs: D=8'h80 then start again in the IDLE cycle after done with D=8'h02 -> Y=7, done, Y=1, done; Cnt=1 after each job.
